// File: rtl/scrambler_tap_sequencer.sv
// scrambler_tap_sequencer
//   Captures the concatenated scrambler polynomial state on an accepted start,
//   then walks a tap select through a programmable tap table, emitting one
//   OUT_W-bit word per select on a valid/ready stream (IDLE -> RUN -> DRAIN).
//   Lane k of the word for select s is snap[tab[s][k]].
//   Optional feature macro: SCR_TAP_PARITY_EN adds out_par_o = ^out_data_o.
module scrambler_tap_sequencer #(
    parameter int TOTAL_W = 2635,
    parameter int OUT_W   = 16,
    parameter int NSEL    = 32,
    parameter int SEL_W   = $clog2(NSEL),
    parameter int IDX_W   = $clog2(TOTAL_W),
    parameter int LANE_W  = $clog2(OUT_W)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [TOTAL_W-1:0] poly_state_i,
    input  logic               start_i,
    input  logic [SEL_W-1:0]   seq_base_i,
    input  logic [SEL_W:0]     seq_len_i,
    input  logic               cfg_we_i,
    input  logic [SEL_W-1:0]   cfg_sel_i,
    input  logic [LANE_W-1:0]  cfg_lane_i,
    input  logic [IDX_W-1:0]   cfg_idx_i,
    output logic               cfg_err_o,
    output logic [OUT_W-1:0]   out_data_o,
    output logic [SEL_W-1:0]   out_sel_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               done_o
`ifdef SCR_TAP_PARITY_EN
    ,
    output logic               out_par_o
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [IDX_W:0]   TOTAL_L = (IDX_W+1)'(TOTAL_W);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NSEL - 1);

    logic [1:0]         state_q,  state_d;
    logic [TOTAL_W-1:0] snap_q,   snap_d;
    logic [SEL_W-1:0]   sel_q,    sel_d;
    logic [SEL_W-1:0]   cnt_q,    cnt_d;
    logic [SEL_W-1:0]   len_m1_q, len_m1_d;
    logic [OUT_W-1:0]   data_q,   data_d;
    logic [SEL_W-1:0]   osel_q,   osel_d;
    logic               valid_q,  valid_d;
    logic               done_q,   done_d;
    logic               err_q,    err_d;

    logic [IDX_W-1:0]   tab_q [NSEL][OUT_W];
    logic [OUT_W-1:0]   word;
    logic               idx_bad;
    logic               tab_we;

    // Reject writes that are out of range or land while a sequence is running.
    assign idx_bad = ({1'b0, cfg_idx_i} >= TOTAL_L);
    assign tab_we  = cfg_we_i && (state_q == S_IDLE) && !idx_bad;
    assign err_d   = cfg_we_i && ((state_q != S_IDLE) || idx_bad);

    // Gather one tap per lane from the snapshot for the current select.
    always_comb begin
        word = '0;
        for (int k = 0; k < OUT_W; k++) begin
            word[k] = snap_q[tab_q[sel_q][k]];
        end
    end

    // Sequencer next-state: start capture, word loading, and final drain.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        snap_d   = snap_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        len_m1_d = len_m1_q;
        data_d   = data_q;
        osel_d   = osel_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    snap_d   = poly_state_i;
                    cnt_d    = '0;
                    sel_d    = seq_base_i;
                    len_m1_d = (seq_len_i == '0) ? SEL_MAX : SEL_W'(seq_len_i - 1'b1);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (!valid_q || out_ready_i) begin
                    data_d  = word;
                    osel_d  = sel_q;
                    valid_d = 1'b1;
                    sel_d   = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == len_m1_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            snap_q   <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            len_m1_q <= '0;
            data_q   <= '0;
            osel_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            len_m1_q <= len_m1_d;
            data_q   <= data_d;
            osel_q   <= osel_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Tap table: one index per (select, lane), default is a linear walk of the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the table is reset on purpose; the power-up mapping must be usable without programming.
        if (!rst_ni) begin
            for (int s = 0; s < NSEL; s++) begin
                for (int k = 0; k < OUT_W; k++) begin
                    tab_q[s][k] <= IDX_W'((s * OUT_W + k) % TOTAL_W);
                end
            end
        end else if (tab_we) begin
            tab_q[cfg_sel_i][cfg_lane_i] <= cfg_idx_i;
        end
    end

`ifdef SCR_TAP_PARITY_EN
    logic par_q;

    // Parity registered alongside the data word so it holds through stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^data_d;
        end
    end

    assign out_par_o = par_q;
`endif

    assign out_data_o  = data_q;
    assign out_sel_o   = osel_q;
    assign out_valid_o = valid_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign cfg_err_o   = err_q;

endmodule

// File: tb/tb_scrambler_tap_sequencer.sv
// Bench for scrambler_tap_sequencer: expected words are pushed to a scoreboard
// when a start is driven and popped when the DUT hands a word downstream.
module tb_scrambler_tap_sequencer;

    localparam int TOTAL_W = 2635;
    localparam int OUT_W   = 16;
    localparam int NSEL    = 32;
    localparam int SEL_W   = 5;
    localparam int IDX_W   = 12;
    localparam int LANE_W  = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [TOTAL_W-1:0] poly_state;
    logic               start;
    logic [SEL_W-1:0]   seq_base;
    logic [SEL_W:0]     seq_len;
    logic               cfg_we;
    logic [SEL_W-1:0]   cfg_sel;
    logic [LANE_W-1:0]  cfg_lane;
    logic [IDX_W-1:0]   cfg_idx;
    logic               cfg_err;
    logic [OUT_W-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;
`ifdef SCR_TAP_PARITY_EN
    logic               out_par;
`endif

    scrambler_tap_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .poly_state_i (poly_state),
        .start_i      (start),
        .seq_base_i   (seq_base),
        .seq_len_i    (seq_len),
        .cfg_we_i     (cfg_we),
        .cfg_sel_i    (cfg_sel),
        .cfg_lane_i   (cfg_lane),
        .cfg_idx_i    (cfg_idx),
        .cfg_err_o    (cfg_err),
        .out_data_o   (out_data),
        .out_sel_o    (out_sel),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .busy_o       (busy),
        .done_o       (done)
`ifdef SCR_TAP_PARITY_EN
        ,
        .out_par_o    (out_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [SEL_W-1:0] sel;
    } exp_t;

    exp_t             sb[$];
    int               tab_m [NSEL][OUT_W];
    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;
    int               acc_cnt = 0;
    int               last_acc_cyc = 0;
    bit               b2b = 1'b0;
    bit               stall_prev = 1'b0;
    logic [OUT_W-1:0] prev_data;
    logic [SEL_W-1:0] prev_sel;
    logic [OUT_W-1:0] last_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NSEL; s++)
            for (int k = 0; k < OUT_W; k++)
                tab_m[s][k] = (s * OUT_W + k) % TOTAL_W;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every accepted word, stall stability and done timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, prev_data);
                check("stall_sel", out_sel, prev_sel);
            end
`ifdef SCR_TAP_PARITY_EN
            if (out_valid) check("parity", out_par, ^out_data);
`endif
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("extra_word", out_sel, 0);
                    check("extra_word_cnt", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("word_data", out_data, e.data);
                    check("word_sel", out_sel, e.sel);
                end
                if (b2b && acc_cnt > 0) check("b2b_gap", cyc - last_acc_cyc, 1);
                last_data    = out_data;
                last_acc_cyc = cyc;
                acc_cnt++;
            end
            if (done) check("done_timing", cyc, last_acc_cyc + 1);
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_sel   = out_sel;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic start_seq(input int base, input int len, input logic [TOTAL_W-1:0] poly);
        int n;
        exp_t e;
        @(posedge clk); #1;
        poly_state = poly;
        start      = 1'b1;
        seq_base   = SEL_W'(base);
        seq_len    = (SEL_W+1)'(len);
        acc_cnt    = 0;
        n = (len == 0) ? NSEL : len;
        for (int i = 0; i < n; i++) begin
            e.sel = SEL_W'((base + i) % NSEL);
            for (int k = 0; k < OUT_W; k++) e.data[k] = poly[tab_m[e.sel][k]];
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("lat_busy", busy, 1'b1);
        check("lat_valid0", out_valid, 1'b0);
        @(negedge clk);
        check("lat_valid1", out_valid, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        #1;
        check({tag, "_idle_valid"}, out_valid, 1'b0);
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (acc_cnt >= n) break;
        end
        check("wait_acc", acc_cnt >= n, 1'b1);
    endtask

    task automatic cfg_write(input int sel, input int lane, input int idx, output logic err);
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_sel  = SEL_W'(sel);
        cfg_lane = LANE_W'(lane);
        cfg_idx  = IDX_W'(idx);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(negedge clk);
        err = cfg_err;
        if (!busy && idx < TOTAL_W) tab_m[sel][lane] = idx;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_sel"}, out_sel, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, cfg_err, 0);
`ifdef SCR_TAP_PARITY_EN
        check({tag, "_par"}, out_par, 0);
`endif
    endtask

    initial begin
        logic [TOTAL_W-1:0] p;
        logic               err;

        rst_n      = 1'b0;
        poly_state = '0;
        start      = 1'b0;
        seq_base   = '0;
        seq_len    = '0;
        cfg_we     = 1'b0;
        cfg_sel    = '0;
        cfg_lane   = '0;
        cfg_idx    = '0;
        out_ready  = 1'b1;
        model_reset();
        #12;
        check_reset_outputs("rst");
        #10 rst_n = 1'b1;

        // Default table with poly bit i = (i%3==0), full 32-word walk.
        for (int i = 0; i < TOTAL_W; i++) p[i] = (i % 3 == 0);
        b2b = 1'b1;
        start_seq(0, 32, p);
        wait_done("full");
        check("full_count", acc_cnt, 32);

        // len=0 means NSEL words.
        for (int i = 0; i < TOTAL_W; i++) p[i] = 1'($urandom_range(0, 1));
        start_seq(7, 0, p);
        wait_done("len0");
        check("len0_count", acc_cnt, 32);

        // Wrap: sels 30,31,0,1 back to back.
        start_seq(30, 4, p);
        wait_done("wrap");
        check("wrap_count", acc_cnt, 4);

        // Stall five cycles on word 2.
        b2b = 1'b0;
        start_seq(5, 6, p);
        wait_acc(1);
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done("stall");
        check("stall_count", acc_cnt, 6);

        // Config: top state bit routed to lane 15 of entry 3.
        b2b = 1'b1;
        cfg_write(3, 15, TOTAL_W - 1, err);
        check("cfg_ok_err", err, 1'b0);
        p = '0;
        p[TOTAL_W-1] = 1'b1;
        start_seq(3, 1, p);
        wait_done("cfg");
        check("cfg_word", last_data, 16'h8000);
        cfg_write(3, 15, TOTAL_W, err);
        check("cfg_bad_err", err, 1'b1);
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 1'b0);
        start_seq(3, 1, p);
        wait_done("cfg_keep");
        check("cfg_keep_word", last_data, 16'h8000);

        // Busy protection: start, cfg write and poly change mid-sequence.
        for (int i = 0; i < TOTAL_W; i++) p[i] = 1'($urandom_range(0, 1));
        start_seq(10, 8, p);
        wait_acc(2);
        @(posedge clk); #1;
        start      = 1'b1;
        seq_base   = '0;
        seq_len    = 6'd3;
        cfg_we     = 1'b1;
        cfg_sel    = 5'd10;
        cfg_lane   = '0;
        cfg_idx    = 12'd7;
        poly_state = ~p;
        @(posedge clk); #1;
        start  = 1'b0;
        cfg_we = 1'b0;
        @(negedge clk);
        check("busy_cfg_err", cfg_err, 1'b1);
        wait_done("busy");
        check("busy_count", acc_cnt, 8);
        @(negedge clk);
        check("busy_no_restart", busy, 1'b0);

        // Reset in the middle of a sequence.
        start_seq(0, 20, p);
        wait_acc(5);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        start_seq(0, 8, p);
        wait_done("after_rst");
        check("after_rst_count", acc_cnt, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
